// File: rtl/read_burst.sv
// Avalon-MM burst read master feeding a show-ahead FIFO; outstanding words are tracked so returns always fit.
// Optional abort input is compiled in with the READ_BURST_ABORT_EN macro.
module read_burst #(
    parameter int AVALON_DATA_WIDTH    = 32,
    parameter int AVALON_ADDRESS_WIDTH = 32,
    parameter int MAX_BURST_COUNT      = 8,
    parameter int BURST_COUNT_WIDTH    = 4,
    parameter int FIFO_DEPTH           = 32,
    parameter int FIFO_DEPTH_LOG2      = 5
) (
    input  logic                            M_AVALON_CLK,
    input  logic                            M_AVALON_RSTN,
    input  logic                            control_fixed_location,
    input  logic [AVALON_ADDRESS_WIDTH-1:0] control_read_base,
    input  logic [AVALON_ADDRESS_WIDTH-1:0] control_read_length,
    input  logic                            control_go,
`ifdef READ_BURST_ABORT_EN
    input  logic                            control_abort,
`endif
    output logic                            control_done,
    output logic                            control_early_done,
    input  logic                            user_read_buffer,
    output logic [AVALON_DATA_WIDTH-1:0]    user_buffer_data,
    output logic                            user_data_available,
    input  logic                            M_AVALON_WAITREQUEST,
    input  logic                            M_AVALON_READDATAVALID,
    input  logic [AVALON_DATA_WIDTH-1:0]    M_AVALON_READDATA,
    output logic [AVALON_ADDRESS_WIDTH-1:0] M_AVALON_ADDRESS,
    output logic                            M_AVALON_READ,
    output logic [AVALON_DATA_WIDTH/8-1:0]  M_AVALON_BYTEENABLE,
    output logic [BURST_COUNT_WIDTH-1:0]    M_AVALON_BURSTCOUNT
);

    localparam int AW         = AVALON_ADDRESS_WIDTH;
    localparam int BYTES      = AVALON_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int CW         = FIFO_DEPTH_LOG2 + 1;
    localparam int SW         = FIFO_DEPTH_LOG2 + 2;
    localparam int PTRW       = FIFO_DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        ISSUE      = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [AW-1:0]          words_left_q, words_left_d;
    logic                   fixed_q, fixed_d;
    logic [CW-1:0]          pending_q, pending_d;
    logic [CW-1:0]          used_q, used_d;
    logic [PTRW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AVALON_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic [BURST_COUNT_WIDTH-1:0] burst;
    logic [AW-1:0]          go_words;
    logic                   space_ok;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic                   abort;

`ifdef READ_BURST_ABORT_EN
    assign abort = control_abort;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        burst = '0;
        if (fixed_q) begin
            burst = BURST_COUNT_WIDTH'(1);
        end else if (words_left_q >= AW'(MAX_BURST_COUNT)) begin
            burst = BURST_COUNT_WIDTH'(MAX_BURST_COUNT);
        end else begin
            burst = words_left_q[BURST_COUNT_WIDTH-1:0];
        end
    end

    // Registered occupancy only: words already in flight are counted as if they had landed.
    assign space_ok = (SW'(used_q) + SW'(pending_q) + SW'(burst)) <= SW'(FIFO_DEPTH);
    assign go_words = control_read_length >> BYTE_SHIFT;
    assign accept   = (state_q == ISSUE) && !M_AVALON_WAITREQUEST;
    assign push     = M_AVALON_READDATAVALID && (pending_q != '0);
    assign pop      = user_read_buffer && (used_q != '0);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        fixed_d      = fixed_q;
        case (state_q)
            IDLE: begin
                if (control_go && control_done) begin
                    addr_d       = control_read_base;
                    words_left_d = go_words;
                    fixed_d      = control_fixed_location;
                    if (go_words != '0) begin
                        state_d = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                if (abort) begin
                    words_left_d = '0;
                    state_d      = IDLE;
                end else if (space_ok) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    words_left_d = words_left_q - AW'(burst);
                    if (!fixed_q) begin
                        addr_d = addr_q + (AW'(burst) << BYTE_SHIFT);
                    end
                    state_d = (words_left_d != '0) ? WAIT_SPACE : IDLE;
                end
                // An accepted burst is still counted in pending even when aborted.
                if (abort) begin
                    words_left_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        if (accept) begin
            pending_d = pending_d + CW'(burst);
        end
        if (push) begin
            pending_d = pending_d - CW'(1);
        end
        used_d   = used_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        if (push && !pop) begin
            used_d = used_q + CW'(1);
        end else if (pop && !push) begin
            used_d = used_q - CW'(1);
        end
    end

    always_ff @(posedge M_AVALON_CLK) begin
        if (!M_AVALON_RSTN) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            fixed_q      <= 1'b0;
            pending_q    <= '0;
            used_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            fixed_q      <= fixed_d;
            pending_q    <= pending_d;
            used_q       <= used_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge M_AVALON_CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= M_AVALON_READDATA;
        end
    end

    assign control_done        = (state_q == IDLE) && (pending_q == '0);
    assign control_early_done  = (words_left_q == '0);
    assign user_buffer_data    = fifo_mem[rd_ptr_q];
    assign user_data_available = (used_q != '0);
    assign M_AVALON_READ       = (state_q == ISSUE);
    assign M_AVALON_ADDRESS    = addr_q;
    assign M_AVALON_BURSTCOUNT = (state_q == ISSUE) ? burst : '0;
    assign M_AVALON_BYTEENABLE = '1;

endmodule

// File: tb/tb_read_burst.sv
// Directed bench for read_burst: behavioural Avalon slave with 1-cycle read latency plus scenario tasks.
module tb_read_burst;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BCW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rstn;
    logic           fixed;
    logic [AW-1:0]  base;
    logic [AW-1:0]  len;
    logic           go;
    logic           done;
    logic           early;
    logic           rbuf;
    logic [DW-1:0]  bdata;
    logic           avail;
    logic           wreq;
    logic           rdv;
    logic [DW-1:0]  rdata;
    logic [AW-1:0]  addr;
    logic           rd;
    logic [DW/8-1:0] be;
    logic [BCW-1:0] bc;
`ifdef READ_BURST_ABORT_EN
    logic           abort;
`endif

    int checks = 0;
    int errors = 0;

    // slave model state
    logic [31:0] ret_q[$];
    logic [31:0] burst_addr[$];
    int          burst_len[$];
    logic [31:0] popped[$];
    int          words_posted = 0;
    int          read_cycles = 0;
    int          wait_left = 0;
    int          wait_seen = 0;
    int          stab_err = 0;
    bit          slave_en = 1'b1;
    bit          held = 1'b0;
    logic [AW-1:0]  held_addr;
    logic [BCW-1:0] held_bc;

    read_burst dut (
        .M_AVALON_CLK          (clk),
        .M_AVALON_RSTN         (rstn),
        .control_fixed_location(fixed),
        .control_read_base     (base),
        .control_read_length   (len),
        .control_go            (go),
`ifdef READ_BURST_ABORT_EN
        .control_abort         (abort),
`endif
        .control_done          (done),
        .control_early_done    (early),
        .user_read_buffer      (rbuf),
        .user_buffer_data      (bdata),
        .user_data_available   (avail),
        .M_AVALON_WAITREQUEST  (wreq),
        .M_AVALON_READDATAVALID(rdv),
        .M_AVALON_READDATA     (rdata),
        .M_AVALON_ADDRESS      (addr),
        .M_AVALON_READ         (rd),
        .M_AVALON_BYTEENABLE   (be),
        .M_AVALON_BURSTCOUNT   (bc)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    initial begin
        rdv   = 1'b0;
        rdata = '0;
        wreq  = 1'b0;
        forever begin
            @(negedge clk);
            if (slave_en && ret_q.size() > 0) begin
                rdv   = 1'b1;
                rdata = word_of(ret_q.pop_front());
            end else begin
                rdv   = 1'b0;
                rdata = '0;
            end
            if (rd === 1'b1) begin
                read_cycles++;
                if (held && (addr !== held_addr || bc !== held_bc)) stab_err++;
                if (wait_left > 0) begin
                    wreq = 1'b1;
                    wait_left--;
                    wait_seen++;
                    if (!held) begin
                        held      = 1'b1;
                        held_addr = addr;
                        held_bc   = bc;
                    end
                end else begin
                    wreq = 1'b0;
                    held = 1'b0;
                    burst_addr.push_back(addr);
                    burst_len.push_back(int'(bc));
                    words_posted += int'(bc);
                    for (int i = 0; i < int'(bc); i++) ret_q.push_back(addr + 32'(i * 4));
                end
            end else begin
                wreq = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        burst_addr.delete();
        burst_len.delete();
        popped.delete();
        words_posted = 0;
        wait_seen    = 0;
        stab_err     = 0;
    endtask

    task automatic start(input logic [31:0] b, input logic [31:0] l, input bit f);
        @(negedge clk);
        base  = b;
        len   = l;
        fixed = f;
        go    = 1'b1;
        @(negedge clk);
        go    = 1'b0;
    endtask

    task automatic drain(input bit pop_en, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done === 1'b1 && avail === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            if (pop_en && avail === 1'b1) begin
                popped.push_back(bdata);
                rbuf = 1'b1;
            end else begin
                rbuf = 1'b0;
            end
        end
        rbuf = 1'b0;
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        go    = 1'b0;
        rbuf  = 1'b0;
        fixed = 1'b0;
        base  = '0;
        len   = '0;
`ifdef READ_BURST_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (rd !== 1'b0)    begin errors++; $display("FAIL reset_read got %0b expected 0", rd); end
        checks++; if (addr !== '0)    begin errors++; $display("FAIL reset_addr got %0h expected 0", addr); end
        checks++; if (bc !== '0)      begin errors++; $display("FAIL reset_bc got %0d expected 0", bc); end
        checks++; if (done !== 1'b1)  begin errors++; $display("FAIL reset_done got %0b expected 1", done); end
        checks++; if (early !== 1'b1) begin errors++; $display("FAIL reset_early got %0b expected 1", early); end
        checks++; if (avail !== 1'b0) begin errors++; $display("FAIL reset_avail got %0b expected 0", avail); end
        checks++; if (be !== 4'hF)    begin errors++; $display("FAIL byteenable got %0h expected f", be); end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        clear_log();
        start(32'h1000, 32'd64, 1'b0);
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL go_done_low got %0b expected 0", done); end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL go_early_low got %0b expected 0", early); end
        drain(1'b1, 300, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got 1 expected 0"); end
        checks++; if (burst_addr.size() != 2) begin errors++; $display("FAIL basic_nbursts got %0d expected 2", burst_addr.size()); end
        if (burst_addr.size() >= 2) begin
            checks++; if (burst_addr[0] !== 32'h1000) begin errors++; $display("FAIL basic_addr0 got %0h expected 1000", burst_addr[0]); end
            checks++; if (burst_addr[1] !== 32'h1020) begin errors++; $display("FAIL basic_addr1 got %0h expected 1020", burst_addr[1]); end
            checks++; if (burst_len[0] != 8 || burst_len[1] != 8) begin errors++; $display("FAIL basic_bc got %0d,%0d expected 8,8", burst_len[0], burst_len[1]); end
        end
        checks++; if (popped.size() != 16) begin errors++; $display("FAIL basic_count got %0d expected 16", popped.size()); end
        for (int i = 0; i < 16 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== word_of(32'h1000 + 32'(4 * i))) begin
                errors++; $display("FAIL basic_data[%0d] got %0h expected %0h", i, popped[i], word_of(32'h1000 + 32'(4 * i)));
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %0b expected 1", done); end
    endtask

    task automatic test_len44();
        bit to;
        clear_log();
        start(32'h1000, 32'd44, 1'b0);
        drain(1'b1, 300, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL len44_timeout got 1 expected 0"); end
        checks++; if (burst_addr.size() != 2) begin errors++; $display("FAIL len44_nbursts got %0d expected 2", burst_addr.size()); end
        if (burst_addr.size() >= 2) begin
            checks++; if (burst_len[0] != 8) begin errors++; $display("FAIL len44_bc0 got %0d expected 8", burst_len[0]); end
            checks++; if (burst_len[1] != 3) begin errors++; $display("FAIL len44_bc1 got %0d expected 3", burst_len[1]); end
            checks++; if (burst_addr[1] !== 32'h1020) begin errors++; $display("FAIL len44_addr1 got %0h expected 1020", burst_addr[1]); end
        end
        checks++; if (popped.size() != 11) begin errors++; $display("FAIL len44_count got %0d expected 11", popped.size()); end
        for (int i = 0; i < 11 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== word_of(32'h1000 + 32'(4 * i))) begin
                errors++; $display("FAIL len44_data[%0d] got %0h expected %0h", i, popped[i], word_of(32'h1000 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_fixed();
        bit to;
        int bad;
        clear_log();
        start(32'h2000, 32'd16, 1'b1);
        drain(1'b1, 300, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL fixed_timeout got 1 expected 0"); end
        checks++; if (burst_addr.size() != 4) begin errors++; $display("FAIL fixed_nbursts got %0d expected 4", burst_addr.size()); end
        bad = 0;
        foreach (burst_addr[i]) if (burst_addr[i] !== 32'h2000 || burst_len[i] != 1) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL fixed_addr_bc got %0d bad bursts expected 0", bad); end
        checks++; if (popped.size() != 4) begin errors++; $display("FAIL fixed_count got %0d expected 4", popped.size()); end
        bad = 0;
        foreach (popped[i]) if (popped[i] !== word_of(32'h2000)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL fixed_data got %0d bad words expected 0", bad); end
    endtask

    task automatic test_no_pop();
        bit to;
        clear_log();
        start(32'h4000, 32'd256, 1'b0);
        repeat (100) @(negedge clk);
        checks++; if (words_posted != 32) begin errors++; $display("FAIL nopop_posted got %0d expected 32", words_posted); end
        checks++; if (rd !== 1'b0)    begin errors++; $display("FAIL nopop_read got %0b expected 0", rd); end
        checks++; if (avail !== 1'b1) begin errors++; $display("FAIL nopop_avail got %0b expected 1", avail); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL nopop_done got %0b expected 0", done); end
        drain(1'b1, 2000, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL nopop_timeout got 1 expected 0"); end
        checks++; if (burst_addr.size() != 8) begin errors++; $display("FAIL nopop_nbursts got %0d expected 8", burst_addr.size()); end
        checks++; if (popped.size() != 64) begin errors++; $display("FAIL nopop_count got %0d expected 64", popped.size()); end
        for (int i = 0; i < 64 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== word_of(32'h4000 + 32'(4 * i))) begin
                errors++; $display("FAIL nopop_data[%0d] got %0h expected %0h", i, popped[i], word_of(32'h4000 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_waitreq();
        bit to;
        clear_log();
        wait_left = 5;
        start(32'h1000, 32'd64, 1'b0);
        drain(1'b1, 300, to);
        checks++; if (to !== 1'b0)    begin errors++; $display("FAIL wait_timeout got 1 expected 0"); end
        checks++; if (wait_seen != 5) begin errors++; $display("FAIL wait_cycles got %0d expected 5", wait_seen); end
        checks++; if (stab_err != 0)  begin errors++; $display("FAIL wait_stable got %0d changes expected 0", stab_err); end
        checks++; if (burst_addr.size() != 2) begin errors++; $display("FAIL wait_nbursts got %0d expected 2", burst_addr.size()); end
        if (burst_addr.size() >= 1) begin
            checks++; if (burst_addr[0] !== 32'h1000 || burst_len[0] != 8) begin errors++; $display("FAIL wait_burst0 got %0h/%0d expected 1000/8", burst_addr[0], burst_len[0]); end
        end
        checks++; if (popped.size() != 16) begin errors++; $display("FAIL wait_count got %0d expected 16", popped.size()); end
        for (int i = 0; i < 16 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== word_of(32'h1000 + 32'(4 * i))) begin
                errors++; $display("FAIL wait_data[%0d] got %0h expected %0h", i, popped[i], word_of(32'h1000 + 32'(4 * i)));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        slave_en = 1'b0;
        start(32'h3000, 32'd24, 1'b0);
        repeat (6) @(negedge clk);
        checks++; if (words_posted != 6) begin errors++; $display("FAIL rmid_posted got %0d expected 6", words_posted); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rmid_pending_done got %0b expected 0", done); end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (rd !== 1'b0)    begin errors++; $display("FAIL rmid_read got %0b expected 0", rd); end
        checks++; if (addr !== '0)    begin errors++; $display("FAIL rmid_addr got %0h expected 0", addr); end
        checks++; if (bc !== '0)      begin errors++; $display("FAIL rmid_bc got %0d expected 0", bc); end
        checks++; if (done !== 1'b1)  begin errors++; $display("FAIL rmid_done got %0b expected 1", done); end
        checks++; if (early !== 1'b1) begin errors++; $display("FAIL rmid_early got %0b expected 1", early); end
        checks++; if (avail !== 1'b0) begin errors++; $display("FAIL rmid_avail got %0b expected 0", avail); end
        rstn     = 1'b1;
        slave_en = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (avail !== 1'b0) begin errors++; $display("FAIL late_avail got %0b expected 0", avail); end
        checks++; if (done !== 1'b1)  begin errors++; $display("FAIL late_done got %0b expected 1", done); end
        checks++; if (rd !== 1'b0)    begin errors++; $display("FAIL late_read got %0b expected 0", rd); end
    endtask

`ifdef READ_BURST_ABORT_EN
    task automatic test_abort();
        bit to;
        int rc0;
        clear_log();
        start(32'h5000, 32'd256, 1'b0);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (burst_addr.size() >= 1) break;
        end
        abort = 1'b1;
        rc0   = read_cycles;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (early !== 1'b1) begin errors++; $display("FAIL abort_early got %0b expected 1", early); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL abort_done_early got %0b expected 0", done); end
        drain(1'b1, 300, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL abort_timeout got 1 expected 0"); end
        checks++; if (read_cycles != rc0) begin errors++; $display("FAIL abort_read got %0d extra read cycles expected 0", read_cycles - rc0); end
        checks++; if (words_posted != 8) begin errors++; $display("FAIL abort_posted got %0d expected 8", words_posted); end
        checks++; if (popped.size() != 8) begin errors++; $display("FAIL abort_count got %0d expected 8", popped.size()); end
        for (int i = 0; i < 8 && i < popped.size(); i++) begin
            checks++;
            if (popped[i] !== word_of(32'h5000 + 32'(4 * i))) begin
                errors++; $display("FAIL abort_data[%0d] got %0h expected %0h", i, popped[i], word_of(32'h5000 + 32'(4 * i)));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_len44();
        test_fixed();
        test_no_pop();
        test_waitreq();
        test_reset_mid();
`ifdef READ_BURST_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
